// File: rtl/control_unit_pkg.sv
// Shared encodings for the microprogrammed control unit.
// Sequencing select fields and fixed microstore entry points.
package control_unit_pkg;

    typedef enum logic [2:0] {
        NS_ENCODER = 3'd0,
        NS_FETCH   = 3'd1,
        NS_CR      = 3'd2,
        NS_INCR    = 3'd3,
        NS_CCR     = 3'd4,
        NS_CENC    = 3'd5,
        NS_CALL    = 3'd6,
        NS_RET     = 3'd7
    } nsel_e;

    typedef enum logic [1:0] {
        CS_MOC  = 2'd0,
        CS_COND = 2'd1,
        CS_IRQ  = 2'd2,
        CS_ONE  = 2'd3
    } ssel_e;

    localparam int FETCH_STATE = 1;
    localparam int FAULT_STATE = 125;

endpackage

// File: rtl/next_state_mux.sv
// Combinational target selector for the microsequencer.
// Picks the next microstore address from the n_sel field.
module next_state_mux
    import control_unit_pkg::*;
#(
    parameter int STATE_W    = 10,
    parameter int FETCH_ADDR = 1
) (
    input  logic [2:0]         n_sel_i,
    input  logic               cond_i,
    input  logic [STATE_W-1:0] cr_i,
    input  logic [STATE_W-1:0] encoder_i,
    input  logic [STATE_W-1:0] incr_i,
    input  logic [STATE_W-1:0] ret_i,
    output logic [STATE_W-1:0] target_o
);

    localparam logic [STATE_W-1:0] FETCH_A = STATE_W'(FETCH_ADDR);

    nsel_e sel;
    assign sel = nsel_e'(n_sel_i);

    always_comb begin
        target_o = incr_i;
        unique case (sel)
            NS_ENCODER: target_o = encoder_i;
            NS_FETCH:   target_o = FETCH_A;
            NS_CR:      target_o = cr_i;
            NS_INCR:    target_o = incr_i;
            NS_CCR:     target_o = cond_i ? cr_i : incr_i;
            NS_CENC:    target_o = cond_i ? encoder_i : incr_i;
            NS_CALL:    target_o = cr_i;
            NS_RET:     target_o = ret_i;
            default:    target_o = incr_i;
        endcase
    end

endmodule

// File: rtl/microsequencer.sv
// Next-address generator for the microstore, with a one-deep
// return register and a watchdog on MOC wait loops.
module microsequencer #(
    parameter int STATE_W     = 10,
    parameter int NUM_STATES  = 126,
    parameter int FETCH_STATE = control_unit_pkg::FETCH_STATE,
    parameter int FAULT_STATE = control_unit_pkg::FAULT_STATE,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] current_state,
    input  logic [2:0]         n_sel,
    input  logic               inv,
    input  logic [1:0]         s_sel,
    input  logic [STATE_W-1:0] cr,
    input  logic [STATE_W-1:0] encoder_state,
    input  logic               moc,
    input  logic               cond,
    input  logic               irq,
    input  logic               hold,
    output logic [STATE_W-1:0] next_state,
    output logic               mem_fault,
    output logic               seq_fault
);

    import control_unit_pkg::*;

    localparam int WCW = $clog2(MOC_TIMEOUT + 1);
    localparam logic [STATE_W-1:0] FAULT_A = STATE_W'(FAULT_STATE);
    localparam logic [STATE_W-1:0] LIMIT_A = STATE_W'(NUM_STATES);
    localparam logic [WCW-1:0]     WLAST   = WCW'(MOC_TIMEOUT - 1);

    logic [STATE_W-1:0] next_q, next_d;
    logic [STATE_W-1:0] incr_q, incr_d;
    logic [STATE_W-1:0] ret_q, ret_d;
    logic               ret_valid_q, ret_valid_d;
    logic [WCW-1:0]     wait_q, wait_d;
    logic               mem_fault_q, mem_fault_d;
    logic               seq_fault_q, seq_fault_d;

    logic               cond_raw;
    logic               c;
    logic [STATE_W-1:0] target;
    logic               moc_loop;
    logic               timeout;
    logic               bad_seq;
    nsel_e              nsel;

    assign nsel = nsel_e'(n_sel);

    always_comb begin
        cond_raw = 1'b1;
        unique case (ssel_e'(s_sel))
            CS_MOC:  cond_raw = moc;
            CS_COND: cond_raw = cond;
            CS_IRQ:  cond_raw = irq;
            CS_ONE:  cond_raw = 1'b1;
            default: cond_raw = 1'b1;
        endcase
    end

    assign c = cond_raw ^ inv;

    next_state_mux #(
        .STATE_W   (STATE_W),
        .FETCH_ADDR(FETCH_STATE)
    ) u_mux (
        .n_sel_i  (n_sel),
        .cond_i   (c),
        .cr_i     (cr),
        .encoder_i(encoder_state),
        .incr_i   (incr_q),
        .ret_i    (ret_q),
        .target_o (target)
    );

    // A self-loop under an MOC test is a bus wait in progress.
    assign moc_loop = (ssel_e'(s_sel) == CS_MOC) &&
                      (target == current_state);
    assign timeout  = moc_loop && (wait_q == WLAST);
    assign bad_seq  = (target >= LIMIT_A) ||
                      ((nsel == NS_RET) && !ret_valid_q);

    always_comb begin
        next_d      = target;
        incr_d      = current_state + 1'b1;
        ret_d       = ret_q;
        ret_valid_d = ret_valid_q;
        wait_d      = moc_loop ? wait_q + 1'b1 : '0;
        mem_fault_d = 1'b0;
        seq_fault_d = 1'b0;
        if (hold) begin
            next_d = next_q;
            incr_d = incr_q;
            wait_d = wait_q;
        end else if (timeout) begin
            next_d      = FAULT_A;
            wait_d      = '0;
            mem_fault_d = 1'b1;
        end else if (bad_seq) begin
            next_d      = FAULT_A;
            seq_fault_d = 1'b1;
        end else if (nsel == NS_CALL) begin
            ret_d       = incr_q;
            ret_valid_d = 1'b1;
        end else if (nsel == NS_RET) begin
            ret_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_q      <= '0;
            incr_q      <= STATE_W'(1);
            ret_q       <= '0;
            ret_valid_q <= 1'b0;
            wait_q      <= '0;
            mem_fault_q <= 1'b0;
            seq_fault_q <= 1'b0;
        end else begin
            next_q      <= next_d;
            incr_q      <= incr_d;
            ret_q       <= ret_d;
            ret_valid_q <= ret_valid_d;
            wait_q      <= wait_d;
            mem_fault_q <= mem_fault_d;
            seq_fault_q <= seq_fault_d;
        end
    end

    assign next_state = next_q;
    assign mem_fault  = mem_fault_q;
    assign seq_fault  = seq_fault_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for the microsequencer.
// Each step advances one clock and checks against hand values.
module tb_microsequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] current_state;
    logic [2:0] n_sel;
    logic       inv;
    logic [1:0] s_sel;
    logic [9:0] cr;
    logic [9:0] encoder_state;
    logic       moc;
    logic       cond;
    logic       irq;
    logic       hold;
    logic [9:0] next_state;
    logic       mem_fault;
    logic       seq_fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    microsequencer dut (
        .clk          (clk),
        .reset        (reset),
        .current_state(current_state),
        .n_sel        (n_sel),
        .inv          (inv),
        .s_sel        (s_sel),
        .cr           (cr),
        .encoder_state(encoder_state),
        .moc          (moc),
        .cond         (cond),
        .irq          (irq),
        .hold         (hold),
        .next_state   (next_state),
        .mem_fault    (mem_fault),
        .seq_fault    (seq_fault)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int ns,
                           input int mf, input int sf);
        chk({tag, ".next"}, int'(next_state), ns);
        chk({tag, ".memf"}, int'(mem_fault), mf);
        chk({tag, ".seqf"}, int'(seq_fault), sf);
    endtask

    initial begin
        reset = 1'b0;
        current_state = '0;
        n_sel = 3'd3;
        inv = 1'b0;
        s_sel = 2'd1;
        cr = '0;
        encoder_state = '0;
        moc = 1'b0;
        cond = 1'b0;
        irq = 1'b0;
        hold = 1'b0;
        step();
        chk_out("reset", 0, 0, 0);
        reset = 1'b1;

        step();
        chk_out("first_incr", 1, 0, 0);

        current_state = 10'd11;
        step();
        chk_out("incr_pre", 1, 0, 0);
        current_state = 10'd12;
        step();
        chk_out("incr12", 12, 0, 0);

        n_sel = 3'd0;
        encoder_state = 10'd20;
        step();
        chk_out("encoder", 20, 0, 0);

        current_state = 10'd1023;
        step();
        n_sel = 3'd3;
        current_state = 10'd5;
        step();
        chk_out("wrap", 0, 0, 0);

        n_sel = 3'd4;
        cr = 10'd64;
        cond = 1'b1;
        step();
        chk_out("ccr_taken", 64, 0, 0);
        inv = 1'b1;
        step();
        chk_out("ccr_inv", 6, 0, 0);

        inv = 1'b0;
        cond = 1'b0;
        n_sel = 3'd3;
        current_state = 10'd30;
        step();
        chk_out("pre_call", 6, 0, 0);
        n_sel = 3'd6;
        cr = 10'd82;
        step();
        chk_out("call", 82, 0, 0);
        n_sel = 3'd7;
        current_state = 10'd82;
        step();
        chk_out("return", 31, 0, 0);
        step();
        chk_out("ret_empty", 125, 0, 1);
        n_sel = 3'd3;
        step();
        chk_out("seqf_pulse", 83, 0, 0);

        current_state = 10'd41;
        n_sel = 3'd4;
        s_sel = 2'd0;
        inv = 1'b1;
        cr = 10'd41;
        moc = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            step();
            chk_out($sformatf("moc_wait%0d", i), 41, 0, 0);
        end
        step();
        chk_out("moc_timeout", 125, 1, 0);
        s_sel = 2'd1;
        n_sel = 3'd3;
        step();
        chk_out("memf_pulse", 42, 0, 0);

        n_sel = 3'd4;
        s_sel = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_out($sformatf("moc_b%0d", i), 41, 0, 0);
        end
        moc = 1'b1;
        step();
        chk_out("moc_done", 42, 0, 0);
        moc = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            step();
            chk_out($sformatf("moc_c%0d", i), 41, 0, 0);
        end

        s_sel = 2'd1;
        n_sel = 3'd2;
        cr = 10'd50;
        hold = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_out($sformatf("hold%0d", i), 41, 0, 0);
        end
        hold = 1'b0;
        step();
        chk_out("hold_rel", 50, 0, 0);
        cr = 10'd126;
        step();
        chk_out("illegal", 125, 0, 1);
        cr = 10'd42;
        step();
        chk_out("cr42", 42, 0, 0);

        #2;
        reset = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0);
        n_sel = 3'd3;
        current_state = 10'd0;
        #1;
        reset = 1'b1;
        step();
        chk_out("rst_release", 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Next-state address generator for the microprogrammed control unit. It is the producer side of the microstore's `next_state` interface.
- Each clock it combines four things: the current microstore state, the control-word sequencing fields, the instruction-encoder target and the status conditions. From these it selects and registers the next microstore address.
- It adds a one-deep micro-subroutine return register and a memory-operation-complete (MOC) wait watchdog.

Parameters:
- STATE_W, 10, width of microstore state addresses.
- NUM_STATES, 126, number of valid microstore states. Any target >= NUM_STATES is illegal.
- FETCH_STATE, 1, first state of the instruction-fetch sequence.
- FAULT_STATE, 125, state entered on a sequencing fault.
- MOC_TIMEOUT, 15, maximum consecutive cycles spent waiting on MOC.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- current_state, input, STATE_W, state currently presented by the microstore.
- n_sel, input, 3, next-state select field of the control word.
- inv, input, 1, inverts the selected condition.
- s_sel, input, 2, condition select: 0=moc, 1=cond, 2=irq, 3=constant 1.
- cr, input, STATE_W, control-register target address field.
- encoder_state, input, STATE_W, first state of the decoded instruction.
- moc, input, 1, memory operation complete.
- cond, input, 1, branch condition result from the condition tester.
- irq, input, 1, interrupt pending.
- hold, input, 1, freezes all sequencer state for one cycle.
- next_state, output, STATE_W, registered next address driven to the microstore.
- mem_fault, output, 1, one-cycle pulse on MOC watchdog expiry.
- seq_fault, output, 1, one-cycle pulse on an illegal target or a return with no valid return address.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - next_state=0, incr_q=1, ret_q=0, ret_valid=0, wait_cnt=0, mem_fault=0, seq_fault=0.
  - Deassertion is synchronous to clk.
- incr_q is registered current_state+1, updated every non-held cycle, modulo 2^STATE_W (1023+1 -> 0).
- Condition: c = selected condition XOR inv.
- n_sel decode; the result is registered into next_state at the next edge (latency 1 cycle):
  - 0: encoder_state
  - 1: FETCH_STATE
  - 2: cr
  - 3: incr_q
  - 4: c ? cr : incr_q
  - 5: c ? encoder_state : incr_q
  - 6: call — target cr; ret_q <= incr_q, ret_valid <= 1
  - 7: return — target ret_q; ret_valid <= 0
- Return with ret_valid=0: next_state <= FAULT_STATE and seq_fault pulses.
- A call while ret_valid=1 overwrites ret_q; this is not a fault.
- Illegal target (>= NUM_STATES) after selection: next_state <= FAULT_STATE and seq_fault pulses. The call/return register update is suppressed.
- MOC watchdog:
  - wait_cnt increments on each cycle where s_sel=0 and the selected target equals current_state (self-loop on MOC).
  - wait_cnt clears on any other cycle.
  - When wait_cnt reaches MOC_TIMEOUT: next_state <= FAULT_STATE, mem_fault pulses, wait_cnt clears.
- hold=1: every register keeps its value, including next_state, incr_q, ret_q and wait_cnt. Fault outputs are 0.
- Priority when multiple events coincide: reset > hold > mem_fault > seq_fault > normal selection.
- The fault pulses last exactly one cycle and are registered with next_state.

Decomposition:
- Shared package `control_unit_pkg` holds:
  - n_sel encodings: NS_ENCODER, NS_FETCH, NS_CR, NS_INCR, NS_CCR, NS_CENC, NS_CALL, NS_RET.
  - s_sel encodings: CS_MOC, CS_COND, CS_IRQ, CS_ONE.
  - FETCH_STATE and FAULT_STATE constants.
- One sub-module: `next_state_mux`, a combinational selector taking the n_sel, condition, cr, encoder_state, incr_q and ret_q inputs and producing the selected target. The registers, watchdog and faults stay in `microsequencer`.

Test Plan:
- Reset: reset=0 mid-run with next_state=42 -> next_state=0 immediately (asynchronous), both faults 0. First edge after release with n_sel=3, current_state=0 -> next_state=1.
- Sequential selection: current_state=12, n_sel=3 (incr_q=12 registered from the prior cycle's current_state=11) -> next_state=12. Encoder dispatch: n_sel=0, encoder_state=20 -> next_state=20. Wrap: current_state=1023, then n_sel=3 next cycle -> next_state=0.
- Conditional: n_sel=4, s_sel=1, cr=64, cond=1, inv=0 -> 64. Same with inv=1 -> incr_q.
- Call/return: current_state=30, n_sel=6, cr=82 -> next_state=82, ret_q=31. Later n_sel=7 -> next_state=31. A second n_sel=7 -> next_state=125, seq_fault pulse.
- MOC watchdog: current_state=41, n_sel=4, s_sel=0, inv=1, cr=41, moc=0 held. next_state stays 41 for 14 edges, then on the 15th edge next_state=125 with one mem_fault pulse. With moc=1 at the 5th cycle -> incr_q is taken and wait_cnt=0.
- Hold and illegal target: hold=1 for 3 cycles with n_sel=2, cr=50 -> next_state unchanged. After hold drops -> 50. Then cr=126 -> next_state=125, seq_fault pulse.
